// File: rtl/reg_context_engine.sv
`timescale 1ns/1ps
// Context sequencer: streams register-file port X into scratch RAM (save)
// and streams scratch RAM back into the register file (restore).
module reg_context_engine #(
  parameter int         NUM_REGS = 32,
  parameter logic [7:0] SCR_BASE = 8'hE0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SAVE,
  input  logic       RESTORE,
  input  logic [7:0] RF_DX_OUT,
  output logic [4:0] RF_ADRX,
  output logic [7:0] RF_DIN,
  output logic       RF_WR,
  output logic [7:0] SCR_ADDR,
  output logic [9:0] SCR_DATA_OUT,
  input  logic [9:0] SCR_DATA_IN,
  output logic       SCR_WE,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_ST,
    RESTORE_RD,
    RESTORE_WR,
    DONE_ST
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t     state;
  logic [4:0] idx;
  logic [7:0] scr_addr;
  logic       last_idx;
  logic       unused_scr_tag;

  // Scratch slot of the current register; the 8-bit sum wraps past 8'hFF.
  assign scr_addr       = SCR_BASE + {3'b000, idx};
  assign last_idx       = (idx == LAST_IDX);
  assign unused_scr_tag = ^SCR_DATA_IN[9:8];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          idx <= '0;
          if (SAVE)         state <= SAVE_ST;
          else if (RESTORE) state <= RESTORE_RD;
        end
        SAVE_ST: begin
          if (last_idx) state <= DONE_ST;
          else          idx   <= idx + 5'd1;
        end
        RESTORE_RD: state <= RESTORE_WR;
        RESTORE_WR: begin
          if (last_idx) begin
            state <= DONE_ST;
          end else begin
            idx   <= idx + 5'd1;
            state <= RESTORE_RD;
          end
        end
        DONE_ST: begin
          idx   <= '0;
          state <= IDLE;
        end
        default: begin
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are a pure decode of state/idx so reset silences them at once.
  always_comb begin
    RF_ADRX      = '0;
    RF_DIN       = '0;
    RF_WR        = 1'b0;
    SCR_ADDR     = '0;
    SCR_DATA_OUT = '0;
    SCR_WE       = 1'b0;
    BUSY         = 1'b0;
    DONE         = 1'b0;
    case (state)
      SAVE_ST: begin
        RF_ADRX      = idx;
        SCR_ADDR     = scr_addr;
        SCR_DATA_OUT = {2'b00, RF_DX_OUT};
        SCR_WE       = 1'b1;
        BUSY         = 1'b1;
      end
      RESTORE_RD: begin
        SCR_ADDR = scr_addr;
        BUSY     = 1'b1;
      end
      RESTORE_WR: begin
        SCR_ADDR = scr_addr;
        RF_ADRX  = idx;
        RF_DIN   = SCR_DATA_IN[7:0];
        RF_WR    = 1'b1;
        BUSY     = 1'b1;
      end
      DONE_ST: begin
        DONE = 1'b1;
        BUSY = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/reg_context_engine.md
Name: reg_context_engine

Overview:
- Hardware sequencer that dumps the RAT CPU register file into scratch RAM (SAVE) and reloads it from scratch RAM (RESTORE). Used by interrupt entry and exit.
- It drives the register file's port-X address, write data and write strobe, and reads the register file's asynchronous DX_OUT.
- The top level muxes this block's RF and scratch ports onto the shared buses while BUSY=1.

Parameters:
NUM_REGS, 32, registers transferred, indices 0..NUM_REGS-1; legal range 1..32
SCR_BASE, 8'hE0, scratch RAM address of register 0

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous reset, active-high
SAVE  input  1  start save; sampled only in IDLE
RESTORE  input  1  start restore; sampled only in IDLE
RF_DX_OUT  input  8  register file async read data for RF_ADRX
RF_ADRX  output  5  register file address
RF_DIN  output  8  register file write data
RF_WR  output  1  register file write enable
SCR_ADDR  output  8  scratch RAM address
SCR_DATA_OUT  output  10  scratch write data, bits [9:8] always 0
SCR_DATA_IN  input  10  scratch read data, valid one cycle after SCR_ADDR is presented (synchronous read)
SCR_WE  output  1  scratch write enable
BUSY  output  1  high in every non-IDLE state
DONE  output  1  one-cycle pulse when a transfer completes

Behaviour:
- State register and 5-bit index idx reset asynchronously to IDLE and 0.
- All outputs are decoded combinationally from state and idx.
- In IDLE, every output is 0. This is also the value of every output during and immediately after reset.
- Address rule: SCR_ADDR = (SCR_BASE + idx) mod 256. An 8-bit sum wraps with no error.
- IDLE:
  - SAVE=1 at a clock edge -> SAVE_ST, idx=0.
  - Otherwise RESTORE=1 -> RESTORE_RD, idx=0. SAVE has priority when both are high.
  - Otherwise stay in IDLE.
- SAVE_ST (one register per cycle):
  - RF_ADRX=idx, SCR_WE=1, SCR_ADDR per rule, SCR_DATA_OUT={2'b00, RF_DX_OUT}, RF_WR=0.
  - At the edge: if idx==NUM_REGS-1, go to DONE_ST; else idx+1.
  - Save takes NUM_REGS cycles of SCR_WE.
- RESTORE_RD:
  - SCR_ADDR per rule, SCR_WE=0, RF_WR=0.
  - Next state is always RESTORE_WR.
- RESTORE_WR:
  - SCR_ADDR held, RF_ADRX=idx, RF_DIN=SCR_DATA_IN[7:0], RF_WR=1. Bits [9:8] of SCR_DATA_IN are ignored.
  - At the edge: if idx==NUM_REGS-1, go to DONE_ST; else idx+1 and return to RESTORE_RD.
  - Restore takes 2*NUM_REGS cycles.
- DONE_ST:
  - DONE=1 and BUSY=1 for exactly one cycle, no strobes, then IDLE.
  - A new SAVE or RESTORE can be accepted at the first IDLE cycle after DONE_ST.
- SAVE or RESTORE asserted while BUSY=1 is ignored. Requests are not queued.
- SAVE and RESTORE are level-sampled. A request held high through DONE starts another transfer on the next IDLE edge.
- Reset mid-transfer:
  - State goes to IDLE and all outputs drop to 0 immediately (asynchronous).
  - No DONE is produced.
  - Registers or scratch locations already written keep their new values.
- idx never exceeds NUM_REGS-1. With NUM_REGS=1, save is 1 WE cycle and restore is 2 cycles.
- Latency from the accepting edge to the DONE pulse:
  - Save: NUM_REGS cycles of SAVE_ST, then DONE_ST.
  - Restore: 2*NUM_REGS cycles of RESTORE_RD/RESTORE_WR, then DONE_ST.

Test Plan:
- Save with defaults: RF reg i preloaded with 8'h10+i, pulse SAVE -> 32 consecutive SCR_WE cycles at addresses E0..FF with data 10'h010..10'h02F. Then DONE high for one cycle. BUSY high for 33 cycles.
- Restore with defaults: scratch E0+i holds 10'h3A0+i, pulse RESTORE -> RF_WR every second cycle; reg i ends with 8'hA0+i, bits [9:8] dropped. DONE follows after 64 busy cycles.
- Priority and ignore: SAVE and RESTORE high in the same IDLE cycle -> save runs and no RF_WR is issued. RESTORE pulsed mid-save -> no effect, exactly one DONE.
- Wrap: SCR_BASE=8'hFE, NUM_REGS=4, save -> SCR_ADDR sequence FE, FF, 00, 01.
- Reset mid-op: RST asserted during restore at idx=5 -> all outputs 0 before the next edge, no DONE. Regs 0..4 restored, regs 5..31 unchanged. A subsequent SAVE runs normally from idx 0.
- Minimal config: NUM_REGS=1, save -> 1 WE cycle then DONE. Restore -> RD, WR, DONE.
